conv_encoder: RTL and testbench

- Rate-1/2 convolutional encoder; the transmit-side counterpart of the Viterbi decoder (same code, generators and symbol bit order the decoder's branch-metric/compare path consumes).
- Accepts a framed serial bit stream and emits one 2-bit code symbol per input bit.
- Appends K-1 zero tail bits per frame so the trellis terminates in state 0, which the decoder traceback relies on.
- Valid/ready on both sides; single output register; full throughput of 1 symbol/clock.

---
 rtl/viterbi_pkg.sv | 24 ++
 rtl/conv_encoder.sv | 113 +++++++++++
 tb/tb_conv_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared code definition for the rate-1/2 convolutional encoder and the
// Viterbi decoder: constraint length, generators and the symbol function.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    // tap MSB is the current bit; result is {G0 parity, G1 parity}
    function automatic logic [1:0] conv_sym(
        input logic [K-1:0] tap,
        input logic [K-1:0] g0,
        input logic [K-1:0] g1
    );
        return {^(g0 & tap), ^(g1 & tap)};
    endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2 framed convolutional encoder with zero-tail termination.
// One registered output symbol, valid/ready on both sides.
module conv_encoder #(
    parameter int            K       = viterbi_pkg::K,
    parameter logic [K-1:0]  G0      = viterbi_pkg::G0_DEF,
    parameter logic [K-1:0]  G1      = viterbi_pkg::G1_DEF,
    parameter bit            TAIL_EN = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data_valid,
    input  logic       i_data_bit,
    input  logic       i_data_last,
    output logic       o_data_ready,
    output logic       o_sym_valid,
    output logic [1:0] o_sym,
    output logic       o_sym_last,
    input  logic       i_sym_ready,
    output logic       o_busy
);
    import viterbi_pkg::*;

    localparam int CW = (K > 2) ? $clog2(K - 1) : 1;

    enc_state_t    state_q, state_d;
    logic [K-2:0]  s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sym_q, sym_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          adv, acc, load, b;
    logic [K-1:0]  tap;

    assign adv          = ~valid_q | i_sym_ready;
    assign o_data_ready = adv & (state_q != TAIL);
    assign acc          = i_data_valid & o_data_ready;
    assign load         = adv & (acc | (state_q == TAIL));
    assign b            = (state_q == TAIL) ? 1'b0 : i_data_bit;

    // tap = {b, s[0], ..., s[K-2]}
    always_comb begin
        tap = '0;
        tap[K-1] = b;
        for (int i = 0; i < K - 1; i++) begin
            tap[K-2-i] = s_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (adv) begin
            valid_d = load;
            last_d  = 1'b0;
            if (load) begin
                sym_d = conv_sym(tap, G0, G1);
                s_d   = {s_q[K-3:0], b};
            end
            case (state_q)
                IDLE, DATA: begin
                    if (acc) begin
                        if (!i_data_last) begin
                            state_d = DATA;
                        end else if (TAIL_EN) begin
                            state_d = TAIL;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                            last_d  = 1'b1;
                        end
                    end
                end
                TAIL: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(K - 2)) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            sym_q   <= 2'b00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_sym_valid = valid_q;
    assign o_sym       = sym_q;
    assign o_sym_last  = last_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: table vectors, corner sequences and a randomized
// run against a parity-based reference model of the K=3 (7,5) code.
module tb_conv_encoder;

    localparam int GM0 = 7;
    localparam int GM1 = 5;

    typedef struct {
        logic [1:0] s;
        logic       l;
    } sym_t;

    typedef struct {
        int          n;
        logic [7:0]  bits;
        logic [15:0] syms;
        int          nsym;
        int          busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dv = 1'b0, db = 1'b0, dl = 1'b0, srdy = 1'b1;
    logic       drdy, sv, sl, busy;
    logic [1:0] sym;
    logic       dv1 = 1'b0, db1 = 1'b0, dl1 = 1'b0, srdy1 = 1'b1;
    logic       drdy1, sv1, sl1, busy1;
    logic [1:0] sym1;

    conv_encoder #(.TAIL_EN(1'b1)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_data_valid(dv), .i_data_bit(db), .i_data_last(dl),
        .o_data_ready(drdy),
        .o_sym_valid(sv), .o_sym(sym), .o_sym_last(sl),
        .i_sym_ready(srdy), .o_busy(busy)
    );

    conv_encoder #(.TAIL_EN(1'b0)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_data_valid(dv1), .i_data_bit(db1), .i_data_last(dl1),
        .o_data_ready(drdy1),
        .o_sym_valid(sv1), .o_sym(sym1), .o_sym_last(sl1),
        .i_sym_ready(srdy1), .o_busy(busy1)
    );

    int   checks = 0;
    int   failures = 0;
    sym_t expq[$];
    sym_t capq[$];
    int   hist[$];
    int   busy_cnt = 0;
    int   rdy_lo = 0;
    bit   rand_on = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [1:0] ps = 2'b00;
    vec_t vecs[4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // parity of generator taps over {b, previous bit, bit before that}
    function automatic void enc(input int b, input bit l);
        int   t;
        sym_t e;
        t = b * 4 + hist[0] * 2 + hist[1];
        e.s = 2'(($countones(GM0 & t) % 2) * 2 + ($countones(GM1 & t) % 2));
        e.l = l;
        expq.push_back(e);
        hist.push_front(b);
        void'(hist.pop_back());
    endfunction

    function automatic void model_accept(input int b, input bit l);
        enc(b, 1'b0);
        if (l) begin
            enc(0, 1'b0);
            enc(0, 1'b1);
        end
    endfunction

    function automatic void model_reset();
        expq.delete();
        hist.delete();
        hist.push_back(0);
        hist.push_back(0);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", sv, 1);
                chk("hold_sym", sym, ps);
                chk("hold_last", sl, pl);
            end
            busy_cnt += busy ? 1 : 0;
            rdy_lo   += drdy ? 0 : 1;
            if (sv && srdy) begin
                if (expq.size() == 0) begin
                    chk("unexpected_sym", 1, 0);
                end else begin
                    sym_t e;
                    e = expq.pop_front();
                    chk("sb_sym", sym, e.s);
                    chk("sb_last", sl, e.l);
                end
                capq.push_back('{s: sym, l: sl});
            end
            pv = sv;
            pr = srdy;
            ps = sym;
            pl = sl;
        end
    end

    // called at posedge+2; returns at posedge+2 after the bit is taken
    task automatic send_bit(input logic b, input logic l);
        int t;
        t = 0;
        dv = 1'b1;
        db = b;
        dl = l;
        forever begin
            #1;
            if (drdy) begin
                model_accept(int'(b), l);
                @(posedge clk);
                #2;
                break;
            end
            @(posedge clk);
            #2;
            t++;
            if (t > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        dv = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] bits);
        logic [7:0] v;
        v = bits;
        for (int i = 0; i < n; i++) begin
            send_bit(v[i], i == n - 1);
        end
    endtask

    task automatic wait_caps(input int n);
        int t;
        t = 0;
        while (capq.size() < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (capq.size() < n) chk("cap_timeout", capq.size(), n);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic cmp_caps(input logic [15:0] syms, input int nsym);
        logic [15:0] v;
        v = syms;
        for (int i = 0; i < nsym && i < capq.size(); i++) begin
            chk("tbl_sym", capq[i].s, int'((v >> (2 * i)) & 16'd3));
            chk("tbl_last", capq[i].l, (i == nsym - 1) ? 1 : 0);
        end
    endtask

    initial begin
        logic [1:0] u1_exp [4];
        logic       u1_bit [4];
        logic       u1_lst [4];
        int         nf;
        vecs[0] = '{n: 4, bits: 8'b0000_1101, syms: 16'b1101_0100_1011, nsym: 6, busy: 5};
        vecs[1] = '{n: 1, bits: 8'b0000_0001, syms: 16'b11_1011, nsym: 3, busy: 2};
        vecs[2] = '{n: 2, bits: 8'b0000_0011, syms: 16'b1101_0111, nsym: 4, busy: 3};
        vecs[3] = '{n: 2, bits: 8'b0000_0010, syms: 16'b1110_1100, nsym: 4, busy: 3};
        u1_exp = '{2'b11, 2'b10, 2'b00, 2'b10};
        u1_bit = '{1'b1, 1'b0, 1'b1, 1'b0};
        u1_lst = '{1'b0, 1'b0, 1'b1, 1'b1};
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", sv, 0);
        chk("rst_sym", sym, 0);
        chk("rst_last", sl, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        for (int v = 0; v < 4; v++) begin
            capq.delete();
            busy_cnt = 0;
            rdy_lo = 0;
            send_frame(vecs[v].n, vecs[v].bits);
            wait_caps(vecs[v].nsym);
            cmp_caps(vecs[v].syms, vecs[v].nsym);
            chk("tbl_count", capq.size(), vecs[v].nsym);
            chk("tbl_busy_cycles", busy_cnt, vecs[v].busy);
            chk("tbl_rdy_low", rdy_lo, 2);
        end

        capq.delete();
        send_frame(2, 8'b11);
        send_frame(2, 8'b10);
        wait_caps(8);
        cmp_caps(16'b1101_0111, 4);
        if (capq.size() >= 8) begin
            for (int i = 0; i < 4; i++) capq.pop_front();
            cmp_caps(16'b1110_1100, 4);
        end else begin
            chk("b2b_count", capq.size(), 8);
        end

        capq.delete();
        fork
            send_frame(4, 8'b1101);
            begin
                int t;
                t = 0;
                while (capq.size() < 1 && t < 50) begin
                    @(posedge clk);
                    t++;
                end
                #2;
                srdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_sym", sym, 2'b10);
                    chk("bp_no_accept", drdy, 0);
                    @(posedge clk);
                end
                #2;
                srdy = 1'b1;
            end
        join
        wait_caps(6);
        cmp_caps(16'b1101_0100_1011, 6);

        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("mid_rst_valid", sv, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        capq.delete();
        send_frame(1, 8'b1);
        wait_caps(3);
        cmp_caps(16'b11_1011, 3);

        nf = 0;
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    int n;
                    n = $urandom_range(1, 8);
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #2;
                        end
                        send_bit(1'($urandom_range(0, 1)), i == n - 1);
                    end
                    nf++;
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #2;
                    srdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        srdy = 1'b1;
        begin
            int t;
            t = 0;
            while (expq.size() != 0 && t < 200) begin
                @(posedge clk);
                t++;
            end
            #2;
        end
        chk("rand_drained", expq.size(), 0);
        chk("rand_frames", nf, 30);

        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #2;
            dv1 = 1'b1;
            db1 = u1_bit[k];
            dl1 = u1_lst[k];
            #1;
            chk("notail_rdy", drdy1, 1);
            @(posedge clk);
            #2;
            dv1 = 1'b0;
            @(negedge clk);
            chk("notail_valid", sv1, 1);
            chk("notail_sym", sym1, u1_exp[k]);
            chk("notail_last", sl1, u1_lst[k]);
            chk("notail_busy", busy1, (k < 2) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
